// File: rtl/module_mult_sequencer.sv
// Sequential shift-and-add unsigned multiplier with its own control FSM.
// Captures operands on a start pulse, iterates W cycles, then holds the product.
module module_mult_sequencer #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           calculate_en,
  input  logic           clear,
  input  logic [W-1:0]   numA,
  input  logic [W-1:0]   numB,
  output logic           busy,
  output logic           result_valid,
  output logic [2*W-1:0] result,
  output logic [1:0]     state_leds
);

  localparam int unsigned CntW = $clog2(W + 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e           state_q;
  logic [W-1:0]     mcand_q;
  logic [2*W:0]     prod_q;
  logic [CntW-1:0]  cnt_q;
  logic [2*W-1:0]   result_q;
  logic             busy_q;
  logic             valid_q;

  logic [W:0]       sum;
  logic [2*W:0]     prod_shift;
  logic [CntW-1:0]  cnt_inc;

  // One iteration: conditional add into the high half, then shift right by one.
  always_comb begin
    sum = {1'b0, prod_q[2*W-1:W]};
    if (prod_q[0]) begin
      sum = sum + {1'b0, mcand_q};
    end
    prod_shift = {1'b0, sum, prod_q[W-1:1]};
    cnt_inc    = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else if (clear) begin
      // Clear beats a simultaneous start in every state.
      state_q  <= StIdle;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (calculate_en) begin
            mcand_q <= numA;
            prod_q  <= {{(W + 1){1'b0}}, numB};
            cnt_q   <= '0;
            state_q <= StCalc;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        StCalc: begin
          prod_q <= prod_shift;
          cnt_q  <= cnt_inc;
          if (cnt_inc == CntW'(W)) begin
            result_q <= prod_shift[2*W-1:0];
            state_q  <= StDone;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result       = result_q;
  assign state_leds   = state_q;

endmodule

// File: tb/tb_module_mult_sequencer.sv
// Directed bench for module_mult_sequencer at W=4 with immediate-assertion checks.
module tb_module_mult_sequencer;

  localparam int unsigned W = 4;

  logic           clk;
  logic           rst_n;
  logic           calculate_en;
  logic           clear;
  logic [W-1:0]   numA;
  logic [W-1:0]   numB;
  logic           busy;
  logic           result_valid;
  logic [2*W-1:0] result;
  logic [1:0]     state_leds;

  int checks = 0;
  int errors = 0;

  module_mult_sequencer #(.W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .calculate_en (calculate_en),
    .clear        (clear),
    .numA         (numA),
    .numB         (numB),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .state_leds   (state_leds)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic b, input logic v,
                         input logic [1:0] leds, input logic [2*W-1:0] res);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".valid"}, 32'(result_valid), 32'(v));
    chk({tag, ".leds"}, 32'(state_leds), 32'(leds));
    chk({tag, ".result"}, 32'(result), 32'(res));
  endtask

  // Start a multiply, check busy for exactly W cycles with the old result held, then the product.
  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] old_res, input logic [2*W-1:0] exp_res);
    numA = a;
    numB = b;
    calculate_en = 1'b1;
    tick();
    calculate_en = 1'b0;
    for (int i = 0; i < int'(W) - 1; i++) begin
      chk_all({tag, ".calc"}, 1'b1, 1'b0, 2'b01, old_res);
      tick();
    end
    chk_all({tag, ".calc"}, 1'b1, 1'b0, 2'b01, old_res);
    tick();
    chk_all({tag, ".done"}, 1'b0, 1'b1, 2'b10, exp_res);
  endtask

  initial begin
    rst_n = 1'b0;
    calculate_en = 1'b0;
    clear = 1'b0;
    numA = '0;
    numB = '0;
    #12;
    chk_all("reset", 1'b0, 1'b0, 2'b00, 8'd0);
    #5 rst_n = 1'b1;
    tick();
    chk_all("idle", 1'b0, 1'b0, 2'b00, 8'd0);

    run_mul("m3x5", 4'd3, 4'd5, 8'd0, 8'd15);
    tick();
    chk_all("hold15", 1'b0, 1'b1, 2'b10, 8'd15);
    run_mul("m15x15", 4'd15, 4'd15, 8'd15, 8'd225);
    run_mul("m0x9", 4'd0, 4'd9, 8'd225, 8'd0);

    // 7x6 with an ignored second pulse and operand changes during CALC.
    numA = 4'd7;
    numB = 4'd6;
    calculate_en = 1'b1;
    tick();
    chk_all("m7x6.k", 1'b1, 1'b0, 2'b01, 8'd0);
    numA = 4'd2;
    numB = 4'd2;
    tick();
    calculate_en = 1'b0;
    numA = 4'd15;
    chk_all("m7x6.k1", 1'b1, 1'b0, 2'b01, 8'd0);
    tick();
    tick();
    chk_all("m7x6.k3", 1'b1, 1'b0, 2'b01, 8'd0);
    tick();
    chk_all("m7x6.done", 1'b0, 1'b1, 2'b10, 8'd42);

    // Clear from DONE, then abort a 9x9 in its second CALC cycle.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_all("clr_done", 1'b0, 1'b0, 2'b00, 8'd0);
    numA = 4'd9;
    numB = 4'd9;
    calculate_en = 1'b1;
    tick();
    calculate_en = 1'b0;
    tick();
    chk_all("m9x9.calc", 1'b1, 1'b0, 2'b01, 8'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_all("m9x9.abort", 1'b0, 1'b0, 2'b00, 8'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("m9x9.after", 1'b0, 1'b0, 2'b00, 8'd0);
    end

    // Restart from DONE; old result stays visible until overwritten.
    run_mul("r3x5", 4'd3, 4'd5, 8'd0, 8'd15);
    run_mul("r4x4", 4'd4, 4'd4, 8'd15, 8'd16);

    // Clear and start together in DONE: clear wins.
    numA = 4'd5;
    numB = 4'd5;
    clear = 1'b1;
    calculate_en = 1'b1;
    tick();
    clear = 1'b0;
    calculate_en = 1'b0;
    chk_all("clr_start", 1'b0, 1'b0, 2'b00, 8'd0);
    tick();
    chk_all("clr_start.idle", 1'b0, 1'b0, 2'b00, 8'd0);

    // Asynchronous reset mid-CALC.
    numA = 4'd3;
    numB = 4'd5;
    calculate_en = 1'b1;
    tick();
    calculate_en = 1'b0;
    tick();
    chk_all("arst.pre", 1'b1, 1'b0, 2'b01, 8'd0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("arst", 1'b0, 1'b0, 2'b00, 8'd0);
    #2 rst_n = 1'b1;
    tick();
    chk_all("arst.idle", 1'b0, 1'b0, 2'b00, 8'd0);
    run_mul("post3x5", 4'd3, 4'd5, 8'd0, 8'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
